// File: rtl/seg7_pkg.sv
// Shared types and the segment encoder for the seven-segment up/down counter.
package seg7_pkg;
  typedef enum logic {IDLE, PRESSED} debounce_state_t;
  typedef enum logic [1:0] {RATE0, RATE1, RATE2} scan_rate_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segments a..g, a at the MSB, 1 = lit.
  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// Tick-sampled button debouncer: one press pulse per accepted press, none on release.
module button_debouncer import seg7_pkg::*; #(
  parameter int DEBOUNCE_LEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press
);
  logic [DEBOUNCE_LEN-1:0] shreg, shreg_nx;
  debounce_state_t         state;

  assign shreg_nx = {shreg[DEBOUNCE_LEN-2:0], btn};
  // Decoded from the incoming sample so the count updates on the accepting tick edge.
  assign press    = tick && (state == IDLE) && (&shreg_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      state <= IDLE;
    end else if (tick) begin
      shreg <= shreg_nx;
      if (state == IDLE && (&shreg_nx))
        state <= PRESSED;
      else if (state == PRESSED && !(|shreg_nx))
        state <= IDLE;
    end
  end
endmodule

// File: rtl/seg7_updown_counter.sv
// Multi-digit hex/BCD up/down counter driving a multiplexed common-cathode display.
module seg7_updown_counter import seg7_pkg::*; #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 15,
  parameter int DEBOUNCE_LEN = 32,
  parameter int SCAN_BIT0    = 15,
  parameter int SCAN_BIT1    = 19,
  parameter int SCAN_BIT2    = 25,
  parameter int PRESC_W      = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    ss,
  input  logic                    mode_bcd,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   grounds,
  output logic [6:0]              display,
  output logic [4*NUM_DIGITS-1:0] value
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [PRESC_W-1:0]         presc;
  logic                       tick;
  logic [2:0]                 btns, presses;
  logic                       press_inc, press_dec, press_ss;
  logic [NUM_DIGITS-1:0][3:0] digits, digits_nx;
  logic [3:0]                 dmax;
  logic                       carry, mode_q;
  scan_rate_t                 scan_sel, scan_sel_nx;
  logic                       sel_bit, sel_q, scan_edge;
  logic [IDX_W-1:0]           idx, idx_nx;
  logic [NUM_DIGITS-1:0]      upper_zero;
  logic                       zacc;

  function automatic logic rate_bit(input scan_rate_t r, input logic [PRESC_W-1:0] p);
    case (r)
      RATE1:   return p[SCAN_BIT1];
      RATE2:   return p[SCAN_BIT2];
      default: return p[SCAN_BIT0];
    endcase
  endfunction

  assign tick = &presc[TICK_DIV-1:0];
  assign btns = {ss, dec, inc};
  assign {press_ss, press_dec, press_inc} = presses;

  for (genvar g = 0; g < 3; g++) begin : g_db
    button_debouncer #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btns[g]), .press(presses[g])
    );
  end

  // Ripple carry/borrow; simultaneous inc and dec cancel out.
  always_comb begin
    digits_nx = digits;
    dmax      = mode_bcd ? 4'd9 : 4'd15;
    carry     = 1'b1;
    if (press_inc ^ press_dec) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (press_inc) begin
            if (digits[i] >= dmax) digits_nx[i] = 4'd0;
            else begin digits_nx[i] = digits[i] + 4'd1; carry = 1'b0; end
          end else begin
            if (digits[i] == 4'd0) digits_nx[i] = dmax;
            else begin digits_nx[i] = digits[i] - 4'd1; carry = 1'b0; end
          end
        end
      end
    end
  end

  always_comb begin
    scan_sel_nx = scan_sel;
    if (press_ss) begin
      case (scan_sel)
        RATE0:   scan_sel_nx = RATE1;
        RATE1:   scan_sel_nx = RATE2;
        default: scan_sel_nx = RATE0;
      endcase
    end
  end

  // Edge history follows the newly selected bit so a rate change cannot fake an edge.
  assign sel_bit   = rate_bit(scan_sel, presc);
  assign scan_edge = sel_bit && !sel_q && !press_ss;
  assign idx_nx    = !scan_edge ? idx :
                     (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

  always_comb begin
    zacc       = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc          = zacc && (digits[i] == 4'd0);
      upper_zero[i] = zacc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      digits   <= '0;
      mode_q   <= 1'b0;
      scan_sel <= RATE0;
      sel_q    <= 1'b0;
      idx      <= '0;
      grounds  <= ~NUM_DIGITS'(1);
      display  <= seg7_encode(4'd0);
    end else begin
      presc    <= presc + PRESC_W'(1);
      mode_q   <= mode_bcd;
      digits   <= (mode_bcd != mode_q) ? '0 : digits_nx;
      scan_sel <= scan_sel_nx;
      sel_q    <= rate_bit(scan_sel_nx, presc);
      idx      <= idx_nx;
      grounds  <= ~(NUM_DIGITS'(1) << idx_nx);
      display  <= (blank_lz && idx_nx != '0 && upper_zero[idx_nx]) ? SEG_BLANK
                                                                   : seg7_encode(digits[idx_nx]);
    end
  end

  assign value = digits;
endmodule

// File: tb/tb_seg7_updown_counter.sv
// Scoreboarded random bench: a numeric model predicts each value change, monitors compare.
module tb_seg7_updown_counter;
  localparam int ND = 4;
  localparam logic [6:0] SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic clk = 0, rst_n = 0, inc = 0, dec = 0, ss = 0, mode_bcd = 0, blank_lz = 0;
  logic [ND-1:0]   grounds;
  logic [6:0]      display;
  logic [4*ND-1:0] value;

  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  int unsigned model_n = 0;
  bit model_bcd = 0;
  bit mon_en = 0;
  logic [15:0] last_v, pv;
  logic pbl;
  bit pvalid = 0;
  int iv, k;
  logic [3:0] seen;

  always #5 clk = ~clk;

  seg7_updown_counter #(.NUM_DIGITS(ND), .TICK_DIV(2), .DEBOUNCE_LEN(4), .SCAN_BIT0(3),
                        .SCAN_BIT1(5), .SCAN_BIT2(7), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .ss(ss), .mode_bcd(mode_bcd),
    .blank_lz(blank_lz), .grounds(grounds), .display(display), .value(value));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_disp(input int unsigned n, input bit bcd);
    logic [15:0] r;
    int unsigned b;
    b = bcd ? 10 : 16;
    r = '0;
    for (int i = 0; i < ND; i++) begin r[i*4 +: 4] = 4'(n % b); n = n / b; end
    return r;
  endfunction

  function automatic logic [6:0] exp_disp(input logic [15:0] v, input logic [3:0] g, input logic bl);
    int d;
    d = 0;
    for (int i = 0; i < ND; i++) if (!g[i]) d = i;
    if (bl && d != 0 && (v >> (4*d)) == 16'h0) return 7'b0000000;
    return SEG[v[4*d +: 4]];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input int unsigned nn, input bit nb);
    logic [15:0] o, w;
    o = to_disp(model_n, model_bcd);
    model_n = nn; model_bcd = nb;
    w = to_disp(model_n, model_bcd);
    if (w != o) exp_q.push_back(w);
  endtask

  // Button levels are held for whole multiples of the 4-clk tick period.
  task automatic op(input bit i, input bit d, input int hold, input int gap);
    int unsigned m;
    m = model_bcd ? 10000 : 65536;
    if (hold >= 4 && i && !d) model_push((model_n + 1) % m, model_bcd);
    else if (hold >= 4 && d && !i) model_push((model_n + m - 1) % m, model_bcd);
    inc = i; dec = d;
    cyc(4*hold);
    inc = 0; dec = 0;
    cyc(4*gap);
  endtask

  task automatic rand_op();
    case ($urandom_range(0, 4))
      0: op(1, 0, $urandom_range(4, 7), $urandom_range(4, 6));
      1: op(0, 1, $urandom_range(4, 7), $urandom_range(4, 6));
      2: op(1, 1, $urandom_range(4, 7), $urandom_range(4, 6));
      3: op(1, 0, $urandom_range(1, 3), 4);
      default: op(0, 1, $urandom_range(1, 3), 4);
    endcase
  endtask

  task automatic toggle_mode();
    model_push(0, !model_bcd);
    mode_bcd = !mode_bcd;
    cyc(1);
    check("mode_clear", value, 0);
    cyc(2);
  endtask

  task automatic wait_change(output int n);
    logic [ND-1:0] g;
    g = grounds; n = 0;
    do begin cyc(1); n++; end while (grounds === g && n < 300);
    if (n >= 300) check("scan_timeout", n, 0);
    else check("scan_rotate", grounds, {g[ND-2:0], g[ND-1]});
  endtask

  task automatic check_reset();
    check("rst_value", value, 0);
    check("rst_grounds", grounds, 4'b1110);
    check("rst_display", display, 7'b1111110);
  endtask

  always @(negedge clk) if (mon_en && value !== last_v) begin
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL value_unexpected: got %h previous %h, none expected", value, last_v);
    end else check("value", value, exp_q.pop_front());
    last_v = value;
  end

  always @(negedge clk) begin
    if (!rst_n) pvalid = 0;
    else begin
      if (pvalid && mon_en) begin
        check("grounds_onehot", $countones(~grounds), 1);
        check("display", display, exp_disp(pv, grounds, pbl));
      end
      pv = value; pbl = blank_lz; pvalid = 1;
    end
  end

  initial begin
    cyc(3);
    check_reset();
    rst_n = 1;
    cyc(2);
    last_v = value; mon_en = 1;
    check("idle_value", value, 0);
    wait_change(iv);
    check("first_scan", grounds, 4'b1101);
    wait_change(iv);
    check("rate0_period", iv, 16);

    // Hex wraps and carries
    op(0, 1, 5, 4);
    check("hex_wrap_dn", value, 16'hFFFF);
    op(1, 0, 6, 4);
    check("hex_wrap_up", value, 16'h0000);
    repeat (16) op(1, 0, $urandom_range(4, 7), $urandom_range(4, 6));
    check("hex_carry", value, 16'h0010);
    op(1, 0, 3, 4);
    repeat (4) begin inc = 1; cyc(4); inc = 0; cyc(4); end
    cyc(16);
    op(1, 1, 5, 4);
    check("no_change", value, 16'h0010);
    repeat (30) rand_op();

    // BCD: carry to hundreds, borrow back, full wrap
    if (model_n == 0) op(1, 0, 4, 4);
    toggle_mode();
    repeat (99) op(1, 0, 4, 4);
    check("bcd_99", value, 16'h0099);
    op(1, 0, 4, 4);
    check("bcd_carry", value, 16'h0100);
    op(0, 1, 4, 4);
    op(0, 1, 5, 4);
    check("bcd_borrow", value, 16'h0098);
    repeat (30) rand_op();
    toggle_mode();
    toggle_mode();
    op(0, 1, 4, 4);
    check("bcd_wrap_dn", value, 16'h9999);
    op(1, 0, 4, 4);
    check("bcd_wrap_up", value, 16'h0000);

    // Leading-zero blanking in hex
    toggle_mode();
    repeat (7) op(1, 0, 4, 4);
    blank_lz = 1;
    cyc(2);
    seen = '0;
    for (k = 0; k < 80; k++) begin
      for (int d = 0; d < ND; d++) if (grounds == ~(4'b0001 << d) && !seen[d]) begin
        seen[d] = 1'b1;
        check("blank_digit", display, (d == 0) ? 7'b1110000 : 7'b0000000);
      end
      cyc(1);
    end
    check("blank_all_digits", seen, 4'hF);

    // Scan rate step
    ss = 1; cyc(4*5); ss = 0; cyc(4*4);
    wait_change(iv);
    wait_change(iv);
    wait_change(iv);
    check("rate1_period", iv, 64);

    // Reset in the middle of a held press
    inc = 1; cyc(4*3);
    model_push(0, 0);
    rst_n = 0; #1;
    check_reset();
    cyc(2);
    rst_n = 1;
    cyc(4*2);
    inc = 0;
    cyc(4*6);
    check("no_inc_after_rst", value, 0);
    wait_change(iv);
    wait_change(iv);
    check("rate_after_rst", iv, 16);
    cyc(4);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
